// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

  // Width needed to count 0..limit inclusive.
  function automatic int wait_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational one-hot grant for the RAM arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority with a port-0 starvation guard.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic [1:0] valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last_grant,
`else
  input  logic [wait_cnt_width(STARVE_LIMIT)-1:0] wait_cnt,
`endif
  output logic [1:0] grant
);

  localparam int WAIT_W = wait_cnt_width(STARVE_LIMIT);

  logic p0_wins;

`ifdef ARB_ROUND_ROBIN_EN
  assign p0_wins = (last_grant == PORT_P1);
`else
  assign p0_wins = (wait_cnt == WAIT_W'(STARVE_LIMIT));
`endif

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = p0_wins ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous RAM between instruction fetch (port 0) and LSU (port 1).
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 14,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p0Valid,
  output logic                     p0Ready,
  input  logic                     p0WEn,
  input  logic [ADDRESS_WIDTH-1:0] p0Addr,
  input  logic [DATA_WIDTH-1:0]    p0DataIn,
  output logic                     p0RspValid,
  output logic [DATA_WIDTH-1:0]    p0DataOut,
  input  logic                     p1Valid,
  output logic                     p1Ready,
  input  logic                     p1WEn,
  input  logic [ADDRESS_WIDTH-1:0] p1Addr,
  input  logic [DATA_WIDTH-1:0]    p1DataIn,
  output logic                     p1RspValid,
  output logic [DATA_WIDTH-1:0]    p1DataOut,
  output logic                     ramWEn,
  output logic [ADDRESS_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0]    ramDataIn,
  input  logic [DATA_WIDTH-1:0]    ramDataOut
);

  logic [1:0] valid;
  logic [1:0] grant;
  owner_t     rsp_owner_reg;
  owner_t     rsp_owner_next;

  // Holding valids low during reset keeps grants and RAM writes off while reset is high.
  assign valid = {p1Valid, p0Valid} & {2{~reset}};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= PORT_P1;
    end else if (grant[PORT_P1]) begin
      last_grant_reg <= PORT_P1;
    end else if (grant[PORT_P0]) begin
      last_grant_reg <= PORT_P0;
    end
  end

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .valid     (valid),
    .last_grant(last_grant_reg),
    .grant     (grant)
  );
`else
  localparam int WAIT_W = wait_cnt_width(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_cnt_reg;

  // Counts cycles port 0 has been left waiting; saturates so the guard stays armed until P0 is served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (!p0Valid || grant[PORT_P0]) begin
      wait_cnt_reg <= '0;
    end else if (wait_cnt_reg != WAIT_W'(STARVE_LIMIT)) begin
      wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
    end
  end

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .valid   (valid),
    .wait_cnt(wait_cnt_reg),
    .grant   (grant)
  );
`endif

  assign p0Ready = grant[PORT_P0];
  assign p1Ready = grant[PORT_P1];

  always_comb begin
    ramWEn    = 1'b0;
    ramAddr   = p0Addr;
    ramDataIn = p0DataIn;
    if (grant[PORT_P1]) begin
      ramWEn    = p1WEn;
      ramAddr   = p1Addr;
      ramDataIn = p1DataIn;
    end else if (grant[PORT_P0]) begin
      ramWEn    = p0WEn;
    end
  end

  always_comb begin
    rsp_owner_next = OWN_NONE;
    if (grant[PORT_P1]) begin
      rsp_owner_next = OWN_P1;
    end else if (grant[PORT_P0]) begin
      rsp_owner_next = OWN_P0;
    end
  end

  // Async clear drops any in-flight response immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_owner_reg <= OWN_NONE;
    end else begin
      rsp_owner_reg <= rsp_owner_next;
    end
  end

  assign p0RspValid = (rsp_owner_reg == OWN_P0);
  assign p1RspValid = (rsp_owner_reg == OWN_P1);
  assign p0DataOut  = ramDataOut;
  assign p1DataOut  = ramDataOut;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural write-first RAM.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk;
  logic          reset;
  logic          p0Valid, p0Ready, p0WEn, p0RspValid;
  logic [AW-1:0] p0Addr;
  logic [DW-1:0] p0DataIn, p0DataOut;
  logic          p1Valid, p1Ready, p1WEn, p1RspValid;
  logic [AW-1:0] p1Addr;
  logic [DW-1:0] p1DataIn, p1DataOut;
  logic          ramWEn;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDataIn;
  logic [DW-1:0] ramDataOut;

  int tests_run;
  int tests_failed;

  mem_port_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p0Valid   (p0Valid),
    .p0Ready   (p0Ready),
    .p0WEn     (p0WEn),
    .p0Addr    (p0Addr),
    .p0DataIn  (p0DataIn),
    .p0RspValid(p0RspValid),
    .p0DataOut (p0DataOut),
    .p1Valid   (p1Valid),
    .p1Ready   (p1Ready),
    .p1WEn     (p1WEn),
    .p1Addr    (p1Addr),
    .p1DataIn  (p1DataIn),
    .p1RspValid(p1RspValid),
    .p1DataOut (p1DataOut),
    .ramWEn    (ramWEn),
    .ramAddr   (ramAddr),
    .ramDataIn (ramDataIn),
    .ramDataOut(ramDataOut)
  );

  // Single-port RAM: registered read, write-first.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ramWEn) begin
      mem[ramAddr] <= ramDataIn;
      ramDataOut   <= ramDataIn;
    end else begin
      ramDataOut   <= mem[ramAddr];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    p0Valid = 1'b0; p0WEn = 1'b0; p0Addr = '0; p0DataIn = '0;
    p1Valid = 1'b0; p1WEn = 1'b0; p1Addr = '0; p1DataIn = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    idle_ports();

    // Reset state: no grants, no responses, no RAM write even with a request present.
    step();
    p0Valid = 1'b1; p0WEn = 1'b1; p0Addr = 14'h010;
    #1;
    check("rst_p0Ready", 32'(p0Ready), 32'd0);
    check("rst_ramWEn", 32'(ramWEn), 32'd0);
    check("rst_rspvalid", {30'd0, p1RspValid, p0RspValid}, 32'd0);
    step();
    idle_ports();
    reset = 1'b0;
    step();

    // Preload 0x010 = 0xDEADBEEF through port 0.
    p0Valid = 1'b1; p0WEn = 1'b1; p0Addr = 14'h010; p0DataIn = 32'hDEADBEEF;
    #1;
    check("pre_p0Ready", 32'(p0Ready), 32'd1);
    check("pre_ramWEn", 32'(ramWEn), 32'd1);
    step();
    idle_ports();
    #1;
    check("pre_p0Ack", 32'(p0RspValid), 32'd1);

    // Test 1: port 0 read only.
    step();
    p0Valid = 1'b1; p0Addr = 14'h010;
    #1;
    check("t1_p0Ready", 32'(p0Ready), 32'd1);
    check("t1_p1Ready", 32'(p1Ready), 32'd0);
    check("t1_ramAddr", 32'(ramAddr), 32'h010);
    check("t1_ramWEn", 32'(ramWEn), 32'd0);
    step();
    idle_ports();
    #1;
    check("t1_p0RspValid", 32'(p0RspValid), 32'd1);
    check("t1_p1RspValid", 32'(p1RspValid), 32'd0);
    check("t1_p0DataOut", p0DataOut, 32'hDEADBEEF);
    step();
    check("t1_rsp_one_cycle", 32'(p0RspValid), 32'd0);

`ifndef ARB_ROUND_ROBIN_EN
    // Test 2: both valid continuously; P1 x4 then P0, repeating.
    begin
      int rsp_total = 0;
      p0Valid = 1'b1; p0Addr = 14'h010;
      p1Valid = 1'b1; p1Addr = 14'h010;
      for (int i = 0; i < 10; i++) begin
        logic exp_p0;
        exp_p0 = ((i % 5) == 4);
        #1;
        check($sformatf("t2_grant_p0_%0d", i), 32'(p0Ready), 32'(exp_p0));
        check($sformatf("t2_grant_p1_%0d", i), 32'(p1Ready), 32'(!exp_p0));
        step();
        check($sformatf("t2_rsp_%0d", i), {30'd0, p1RspValid, p0RspValid},
              exp_p0 ? 32'd1 : 32'd2);
        check($sformatf("t2_data_%0d", i), exp_p0 ? p0DataOut : p1DataOut, 32'hDEADBEEF);
        rsp_total += int'(p0RspValid) + int'(p1RspValid);
      end
      check("t2_rsp_total", 32'(rsp_total), 32'd10);
      idle_ports();
      step();
    end
`endif

    // Test 3: P1 write then P0 read of the same address on the next cycle.
    p1Valid = 1'b1; p1WEn = 1'b1; p1Addr = 14'h020; p1DataIn = 32'h12345678;
    #1;
    check("t3_p1Ready", 32'(p1Ready), 32'd1);
    check("t3_ramDataIn", ramDataIn, 32'h12345678);
    step();
    idle_ports();
    p0Valid = 1'b1; p0Addr = 14'h020;
    #1;
    check("t3_p1Ack", 32'(p1RspValid), 32'd1);
    check("t3_p0Ready", 32'(p0Ready), 32'd1);
    step();
    idle_ports();
    #1;
    check("t3_p0RspValid", 32'(p0RspValid), 32'd1);
    check("t3_p0DataOut", p0DataOut, 32'h12345678);
    step();

    // Test 5: reset in the response cycle of a P0 read drops the response.
    p0Valid = 1'b1; p0Addr = 14'h010;
    #1;
    check("t5_p0Ready", 32'(p0Ready), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("t5_rsp_dropped", {30'd0, p1RspValid, p0RspValid}, 32'd0);
    check("t5_ready_in_rst", 32'(p0Ready), 32'd0);
    step();
    idle_ports();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_no_rsp_%0d", i), 32'(p0RspValid), 32'd0);
      step();
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Test 4: round-robin alternates, P0 first after reset.
    p0Valid = 1'b1; p0Addr = 14'h010;
    p1Valid = 1'b1; p1Addr = 14'h010;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t4_grant_p0_%0d", i), 32'(p0Ready), 32'((i % 2) == 0));
      check($sformatf("t4_grant_p1_%0d", i), 32'(p1Ready), 32'((i % 2) == 1));
      step();
    end
    idle_ports();
    step();
`endif

    // Test 6: idle ports; no writes, no responses, RAM intact.
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t6_ramWEn_%0d", i), 32'(ramWEn), 32'd0);
      check($sformatf("t6_rsp_%0d", i), {30'd0, p1RspValid, p0RspValid}, 32'd0);
      step();
    end
    p0Valid = 1'b1; p0Addr = 14'h010;
    step();
    idle_ports();
    #1;
    check("t6_p0RspValid", 32'(p0RspValid), 32'd1);
    check("t6_mem_intact", p0DataOut, 32'hDEADBEEF);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
